tpu_host_seq: RTL and testbench
===============================

TPU_HOST_SEQ -- requirements
Module: tpu_host_seq

Interface
REQ-001 SHALL have parameters: BITS_AB, default 8, A/B element width; BITS_C, default 16, C element width; DIM, default 8, array dimension; ADDRW, default 16, bus address width; DATAW, default 64, bus data width (= DIM*BITS_AB = 4*BITS_C).
REQ-002 SHALL have one clock; reset is asynchronous and active-high.
REQ-003 Ports:
  - clk  in  1  rising-edge clock.
  - rst  in  1  asynchronous active-high reset.
  - in_valid  in  1  job input word valid.
  - in_ready  out  1  job input word accepted.
  - in_data  in  DATAW  A row, then B row words.
  - out_valid  out  1  result word valid.
  - out_ready  in  1  result sink ready.
  - out_data  out  DATAW  C half-row (4 x BITS_C).
  - busy  out  1  job in progress (state != IDLE).
  - tpu_rw  out  1  accelerator bus write strobe (1 = write, 0 = read).
  - tpu_addr  out  ADDRW  accelerator bus address.
  - tpu_wdata  out  DATAW  accelerator bus write data.
  - tpu_rdata  in  DATAW  accelerator bus read data, combinational from tpu_addr.

Function
REQ-004 SHALL sequence one job through states IDLE, LOAD_A, LOAD_B, CLR_C, START, WAIT, READ, returning to IDLE.
REQ-005 IDLE: the first in_valid SHALL be accepted as A row 0 in that cycle, and the state SHALL move to LOAD_A with index 1.
REQ-006 LOAD_A/LOAD_B: in_ready = 1, and each accepted word SHALL drive one write cycle (tpu_rw = 1, tpu_wdata = in_data) combinationally in the accept cycle.
  - A row i address: 0x0100 + 8*i.
  - B row i address: 0x0200 + 8*i.
  - Index runs 0..DIM-1; after DIM accepts in a state, advance to the next state.
REQ-007 When in_valid = 0 in a load state, the block SHALL hold tpu_rw = 0 and tpu_addr = 0x0000, and SHALL NOT advance the index.
REQ-008 CLR_C: in_ready = 0; the block SHALL issue 2*DIM consecutive writes with tpu_wdata = 0.
  - Per row r: address 0x0300 + 16*r (lo half), then 0x0300 + 16*r + 8 (hi half).
  - Rows in ascending order.
REQ-009 START: the block SHALL issue exactly one write cycle to 0x0400 with tpu_wdata = 0.
REQ-010 WAIT: tpu_rw = 0 and tpu_addr = 0x0000 for exactly 3*DIM+1 cycles, counted by a counter of width clog2(3*DIM+2).
REQ-011 READ: tpu_rw = 0; tpu_addr SHALL step through the same 2*DIM C addresses as CLR_C.
  - out_data = tpu_rdata; out_valid = 1.
  - tpu_addr SHALL advance only on out_valid & out_ready.
  - tpu_addr SHALL be held stable while stalled.
REQ-012 After the 2*DIM-th output handshake, the block SHALL return to IDLE, with out_valid = 0 in the next cycle.
REQ-013 in_ready SHALL be 1 only in IDLE, LOAD_A and LOAD_B; out_valid SHALL be 1 only in READ.
REQ-014 Words presented with in_valid outside the load window SHALL NOT be consumed (in_ready = 0).
REQ-015 All address arithmetic SHALL be unsigned ADDRW-bit; the row index width SHALL be clog2(DIM), and the half-select SHALL be 1 bit.
REQ-016 tpu_rw SHALL be a single-cycle strobe per accepted or generated word; the block SHALL NOT issue back-to-back writes to the same address.

Reset
REQ-017 On rst asserted, the block SHALL immediately enter IDLE.
  - in_ready = 1, out_valid = 0, busy = 0.
  - tpu_rw = 0, tpu_addr = 0x0000, tpu_wdata = 0, out_data = tpu_rdata.
  - All counters and indices = 0.
REQ-018 Reset mid-job SHALL abandon the job with no further bus cycles; the next job SHALL restart from A row 0.

Structure
REQ-019 A shared package SHALL hold the following, used by tpu_host_seq and by the benches:
  - Base-address constants: A_BASE 0x0100, B_BASE 0x0200, C_BASE 0x0300, START_ADDR 0x0400, A_STRIDE 8, C_STRIDE 16, C_HI_OFS 8.
  - The state enum typedef.
REQ-020 The block SHALL be a single module with no sub-modules; the address generator SHALL be inline combinational logic driven from state, index and half.

Verification (DIM = 8)
REQ-021 Back-to-back job: in_valid held 1 with 16 words.
  - Writes seen at 0x0100..0x0138, then 0x0200..0x0238, one per cycle.
  - Then 16 zero writes at 0x0300, 0x0308, ..., 0x0378.
  - Then 0x0400 once, then 25 idle cycles.
REQ-022 Gapped input: in_valid toggled 1/0 during the loads.
  - Exactly 16 writes, no address skipped or repeated.
  - tpu_rw = 0 and tpu_addr = 0x0000 on every gap cycle.
REQ-023 READ with out_ready = 1: the bench model returns tpu_rdata = tpu_addr replicated.
  - 16 outputs in order 0x0300, 0x0308, ..., 0x0378.
  - busy falls the cycle after the last handshake.
REQ-024 READ backpressure: out_ready low 3 cycles on the 5th word.
  - tpu_addr held at 0x0320 and out_valid held 1.
  - No output is duplicated or lost.
REQ-025 Reset during WAIT (cycle 10): outputs match REQ-017 in the same cycle; a subsequent full job completes correctly.
REQ-026 End-to-end with tpuv1 instanced: A = identity, B = rows of 1..8.
  - C read-back equals B sign-extended to 16 bits, lo half = columns 0..3, hi half = columns 4..7.

Source files
------------

// File: rtl/tpu_host_seq_pkg.sv
// Shared constants and state encoding for the TPU host sequencer and its benches.
package tpu_host_seq_pkg;

  localparam int A_BASE     = 'h0100;
  localparam int B_BASE     = 'h0200;
  localparam int C_BASE     = 'h0300;
  localparam int START_ADDR = 'h0400;
  localparam int A_STRIDE   = 8;
  localparam int C_STRIDE   = 16;
  localparam int C_HI_OFS   = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    CLR_C,
    START,
    WAIT,
    READ
  } state_t;

endpackage

// File: rtl/tpu_host_seq.sv
// Host-side job sequencer: streams A/B rows into the accelerator, clears C,
// kicks a run, waits for the array to drain, then streams C half-rows out.
module tpu_host_seq
  import tpu_host_seq_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int DIM     = 8,
  parameter int ADDRW   = 16,
  parameter int DATAW   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data,
  output logic             busy,
  output logic             tpu_rw,
  output logic [ADDRW-1:0] tpu_addr,
  output logic [DATAW-1:0] tpu_wdata,
  input  logic [DATAW-1:0] tpu_rdata
);

  localparam int IW        = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int CW        = $clog2(3 * DIM + 2);
  localparam int WAIT_LAST = 3 * DIM;

  state_t          state;
  logic [IW-1:0]   idx;
  logic            half;
  logic [CW-1:0]   cnt;

  logic             load_st;
  logic             accept;
  logic             out_fire;
  logic             last_row;
  logic [ADDRW-1:0] a_addr;
  logic [ADDRW-1:0] b_addr;
  logic [ADDRW-1:0] c_addr;

  assign load_st   = (state == IDLE) || (state == LOAD_A) || (state == LOAD_B);
  assign in_ready  = load_st;
  // A word arriving while reset is held must not reach the bus.
  assign accept    = in_valid & load_st & ~rst;
  assign out_valid = (state == READ);
  assign out_fire  = out_valid & out_ready;
  assign out_data  = DATAW'(tpu_rdata[4*BITS_C-1:0]);
  assign busy      = (state != IDLE);
  assign last_row  = (idx == IW'(DIM - 1));

  assign a_addr = ADDRW'(A_BASE) + ADDRW'(A_STRIDE) * ADDRW'(idx);
  assign b_addr = ADDRW'(B_BASE) + ADDRW'(A_STRIDE) * ADDRW'(idx);
  assign c_addr = ADDRW'(C_BASE) + ADDRW'(C_STRIDE) * ADDRW'(idx)
                + ADDRW'(C_HI_OFS) * ADDRW'(half);

  // Bus drive: IDLE shares the A path since idx is always 0 there.
  always_comb begin
    tpu_rw    = 1'b0;
    tpu_addr  = '0;
    tpu_wdata = '0;
    case (state)
      IDLE, LOAD_A: begin
        if (accept) begin
          tpu_rw    = 1'b1;
          tpu_addr  = a_addr;
          tpu_wdata = DATAW'(in_data[DIM*BITS_AB-1:0]);
        end
      end
      LOAD_B: begin
        if (accept) begin
          tpu_rw    = 1'b1;
          tpu_addr  = b_addr;
          tpu_wdata = DATAW'(in_data[DIM*BITS_AB-1:0]);
        end
      end
      CLR_C: begin
        tpu_rw   = 1'b1;
        tpu_addr = c_addr;
      end
      START: begin
        tpu_rw   = 1'b1;
        tpu_addr = ADDRW'(START_ADDR);
      end
      READ:    tpu_addr = c_addr;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      half  <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= LOAD_A;
            idx   <= IW'(1);
          end
        end
        LOAD_A: begin
          if (accept) begin
            if (last_row) begin
              state <= LOAD_B;
              idx   <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (accept) begin
            if (last_row) begin
              state <= CLR_C;
              idx   <= '0;
              half  <= 1'b0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        CLR_C: begin
          half <= ~half;
          if (half) begin
            if (last_row) begin
              state <= START;
              idx   <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        START: begin
          state <= WAIT;
          cnt   <= '0;
        end
        WAIT: begin
          if (cnt == CW'(WAIT_LAST)) begin
            state <= READ;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        READ: begin
          if (out_fire) begin
            half <= ~half;
            if (half) begin
              if (last_row) begin
                state <= IDLE;
                idx   <= '0;
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_host_seq.sv
// Directed bench for tpu_host_seq with a small behavioural accelerator model on the bus.
module tb_tpu_host_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        busy;
  logic        tpu_rw;
  logic [15:0] tpu_addr;
  logic [63:0] tpu_wdata;
  logic [63:0] tpu_rdata;

  always #5 clk = ~clk;

  tpu_host_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .tpu_rw    (tpu_rw),
    .tpu_addr  (tpu_addr),
    .tpu_wdata (tpu_wdata),
    .tpu_rdata (tpu_rdata)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Accelerator model: mode 0 echoes the address, mode 1 is a real matrix unit.
  bit          mat_mode = 1'b0;
  logic [63:0] a_m [8];
  logic [63:0] b_m [8];
  logic [63:0] c_m [16];
  logic [15:0] wa_q [$];
  logic [63:0] wd_q [$];

  always_comb begin
    tpu_rdata = {4{tpu_addr}};
    if (mat_mode)
      tpu_rdata = (tpu_addr[15:7] == 9'h006) ? c_m[tpu_addr[6:3]] : 64'h0;
  end

  always @(negedge clk) begin
    #2;
    if (tpu_rw === 1'b1) begin
      wa_q.push_back(tpu_addr);
      wd_q.push_back(tpu_wdata);
      if (tpu_addr[15:8] == 8'h01) a_m[tpu_addr[5:3]] = tpu_wdata;
      else if (tpu_addr[15:8] == 8'h02) b_m[tpu_addr[5:3]] = tpu_wdata;
      else if (tpu_addr[15:8] == 8'h03) c_m[tpu_addr[6:3]] = tpu_wdata;
      else if (tpu_addr == 16'h0400) begin
        for (int r = 0; r < 8; r++) begin
          for (int c = 0; c < 8; c++) begin
            int s;
            s = 0;
            for (int k = 0; k < 8; k++)
              s += int'($signed(a_m[r][8*k +: 8])) * int'($signed(b_m[k][8*c +: 8]));
            c_m[2*r + c/4][16*(c%4) +: 16] = s[15:0];
          end
        end
      end
    end
  end

  logic [63:0] a_v [8];
  logic [63:0] b_v [8];
  logic [15:0] rd_addr [16];
  logic [63:0] rd_data [16];

  task automatic drive(input logic v, input logic [63:0] d, input logic r);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
  endtask

  task automatic load_job(input bit gapped, output int rdy_bad, output int gap_bad);
    rdy_bad = 0;
    gap_bad = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, (i < 8) ? a_v[i] : b_v[i-8], 1'b0);
      if (in_ready !== 1'b1) rdy_bad++;
      if (gapped && i < 15) begin
        drive(1'b0, 64'hBAD0_BAD0_BAD0_BAD0, 1'b0);
        if (tpu_rw !== 1'b0 || tpu_addr !== 16'h0000) gap_bad++;
      end
    end
  endtask

  // Runs through clear/start/wait with junk offered on the input side.
  task automatic to_read(input string tag);
    int n, wait_n, rdy_n, waddr_bad;
    n = 0; wait_n = 0; rdy_n = 0; waddr_bad = 0;
    do begin
      drive(1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
      n++;
      if (in_ready) rdy_n++;
      if (!out_valid && !tpu_rw) begin
        wait_n++;
        if (tpu_addr !== 16'h0000) waddr_bad++;
      end
    end while (!out_valid && n < 100);
    chk({tag, "_reach_read"}, out_valid, 1'b1);
    chk({tag, "_wait_cycles"}, wait_n, 25);
    chk({tag, "_wait_addr"}, waddr_bad, 0);
    chk({tag, "_no_accept_busy"}, rdy_n, 0);
  endtask

  task automatic read_job(input string tag, input bit stall);
    int n, st, hs, stall_bad;
    n = 0; st = 0; hs = 0; stall_bad = 0;
    while (hs < 16 && n < 200) begin
      logic r;
      r = !(stall && hs == 4 && st < 3);
      drive(1'b0, 64'h0, r);
      n++;
      if (!r) begin
        st++;
        if (tpu_addr !== 16'h0320 || out_valid !== 1'b1) stall_bad++;
      end
      if (out_valid && r) begin
        rd_addr[hs] = tpu_addr;
        rd_data[hs] = out_data;
        hs++;
      end
    end
    chk({tag, "_handshakes"}, hs, 16);
    if (stall) begin
      chk({tag, "_stall_cycles"}, st, 3);
      chk({tag, "_stall_hold"}, stall_bad, 0);
    end
    drive(1'b0, 64'h0, 1'b1);
    chk({tag, "_busy_after"}, busy, 1'b0);
    chk({tag, "_valid_after"}, out_valid, 1'b0);
  endtask

  task automatic check_writes(input string tag);
    logic [15:0] ea;
    logic [63:0] ed;
    chk({tag, "_wr_count"}, wa_q.size(), 33);
    for (int k = 0; k < 33 && k < wa_q.size(); k++) begin
      if (k < 8)       begin ea = 16'h0100 + 16'(8*k);      ed = a_v[k];   end
      else if (k < 16) begin ea = 16'h0200 + 16'(8*(k-8));  ed = b_v[k-8]; end
      else if (k < 32) begin ea = 16'h0300 + 16'(8*(k-16)); ed = 64'h0;    end
      else             begin ea = 16'h0400;                 ed = 64'h0;    end
      chk($sformatf("%s_wr_addr%0d", tag, k), wa_q[k], ea);
      chk($sformatf("%s_wr_data%0d", tag, k), wd_q[k], ed);
    end
  endtask

  task automatic check_echo_reads(input string tag);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("%s_rd_addr%0d", tag, k), rd_addr[k], 16'h0300 + 16'(8*k));
      chk($sformatf("%s_rd_data%0d", tag, k), rd_data[k], {4{16'h0300 + 16'(8*k)}});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy_bad, gap_bad, w, n;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a_v[i] = 64'hA0A0_0000_0000_0000 | 64'(i * 3 + 1);
      b_v[i] = 64'hB0B0_0000_0000_0000 | 64'(i * 5 + 2);
    end
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rw", tpu_rw, 1'b0);
    chk("rst_addr", tpu_addr, 16'h0000);
    chk("rst_wdata", tpu_wdata, 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Job 1: back-to-back input, no output stalls.
    wa_q.delete(); wd_q.delete();
    load_job(1'b0, rdy_bad, gap_bad);
    chk("j1_in_ready", rdy_bad, 0);
    to_read("j1");
    read_job("j1", 1'b0);
    check_writes("j1");
    check_echo_reads("j1");

    // Job 2: gapped input and output backpressure on the fifth word.
    wa_q.delete(); wd_q.delete();
    load_job(1'b1, rdy_bad, gap_bad);
    chk("j2_in_ready", rdy_bad, 0);
    chk("j2_gap_clean", gap_bad, 0);
    to_read("j2");
    read_job("j2", 1'b1);
    check_writes("j2");
    check_echo_reads("j2");

    // Job 3: reset lands in the middle of the wait window.
    load_job(1'b0, rdy_bad, gap_bad);
    w = 0; n = 0;
    while (w < 10 && n < 100) begin
      drive(1'b0, 64'h0, 1'b0);
      n++;
      if (busy && !tpu_rw && !out_valid) w++;
    end
    chk("j3_reached_wait", w, 10);
    @(negedge clk);
    rst = 1'b1;
    #1;
    wa_q.delete(); wd_q.delete();
    chk("j3_rst_in_ready", in_ready, 1'b1);
    chk("j3_rst_out_valid", out_valid, 1'b0);
    chk("j3_rst_busy", busy, 1'b0);
    chk("j3_rst_rw", tpu_rw, 1'b0);
    chk("j3_rst_addr", tpu_addr, 16'h0000);
    chk("j3_rst_wdata", tpu_wdata, 64'h0);
    chk("j3_rst_out_data", out_data, 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) drive(1'b0, 64'h0, 1'b0);
    chk("j3_no_bus_after_abort", wa_q.size(), 0);
    chk("j3_idle_after_abort", busy, 1'b0);

    // Job 4: end-to-end through the matrix model, A = identity, B rows = 1..8.
    mat_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_v[i] = 64'h1 << (8 * i);
      b_v[i] = 64'h0807_0605_0403_0201;
    end
    wa_q.delete(); wd_q.delete();
    load_job(1'b0, rdy_bad, gap_bad);
    chk("j4_in_ready", rdy_bad, 0);
    to_read("j4");
    read_job("j4", 1'b0);
    check_writes("j4");
    for (int k = 0; k < 16; k++)
      chk($sformatf("j4_c%0d", k), rd_data[k],
          (k % 2 == 0) ? 64'h0004_0003_0002_0001 : 64'h0008_0007_0006_0005);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
